multi_debouncer: RTL



---
 rtl/multi_debouncer.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/multi_debouncer.sv
// multi_debouncer: per-channel push-button conditioner.
// Each channel has a two-flop synchroniser, a stable-count debouncer, and press/release edge pulses.
// Optional feature: define AUTO_REPEAT_EN to build the per-channel auto-repeat generator.
// Without that macro, btn_repeat is tied to 0 and HOLD_CYCLES/REPEAT_CYCLES have no effect.

module multi_debouncer #(
    parameter int unsigned CHANNELS        = 4,
    parameter int unsigned DEBOUNCE_CYCLES = 1000,
    parameter int unsigned HOLD_CYCLES     = 50000,
    parameter int unsigned REPEAT_CYCLES   = 10000
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [CHANNELS-1:0] btn_in,
    output logic [CHANNELS-1:0] btn_level,
    output logic [CHANNELS-1:0] btn_press,
    output logic [CHANNELS-1:0] btn_release,
    output logic [CHANNELS-1:0] btn_repeat
);

    localparam int unsigned CW   = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int unsigned RMAX = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
    localparam int unsigned RW   = $clog2(RMAX + 1);

    logic [CHANNELS-1:0] sync1;
    logic [CHANNELS-1:0] sync2;
    logic [CW-1:0]       cnt_q [CHANNELS];
    logic [CW-1:0]       cnt_d [CHANNELS];
    logic [CHANNELS-1:0] level_q;
    logic [CHANNELS-1:0] level_d;
    logic [CHANNELS-1:0] press_q;
    logic [CHANNELS-1:0] press_d;
    logic [CHANNELS-1:0] release_q;
    logic [CHANNELS-1:0] release_d;

    // Two-flop synchroniser for the asynchronous button pins
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= btn_in;
            sync2 <= sync1;
        end
    end

    // Debounce next-state: count consecutive samples that disagree with the accepted level
    always_comb begin
        level_d   = level_q;
        press_d   = '0;
        release_d = '0;
        for (int ch = 0; ch < CHANNELS; ch++) begin
            cnt_d[ch] = cnt_q[ch];
            if (sync2[ch] == level_q[ch]) begin
                cnt_d[ch] = '0;
            end else if (cnt_q[ch] == CW'(DEBOUNCE_CYCLES - 1)) begin
                level_d[ch]   = ~level_q[ch];
                press_d[ch]   = ~level_q[ch];
                release_d[ch] = level_q[ch];
                cnt_d[ch]     = '0;
            end else begin
                cnt_d[ch] = cnt_q[ch] + CW'(1);
            end
        end
    end

    // Debounce state and registered level/edge outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            level_q   <= '0;
            press_q   <= '0;
            release_q <= '0;
            for (int ch = 0; ch < CHANNELS; ch++) begin
                cnt_q[ch] <= '0;
            end
        end else begin
            level_q   <= level_d;
            press_q   <= press_d;
            release_q <= release_d;
            for (int ch = 0; ch < CHANNELS; ch++) begin
                cnt_q[ch] <= cnt_d[ch];
            end
        end
    end

    assign btn_level   = level_q;
    assign btn_press   = press_q;
    assign btn_release = release_q;

`ifdef AUTO_REPEAT_EN
    typedef enum logic {
        IDLE  = 1'b0,
        ARMED = 1'b1
    } rep_state_t;

    rep_state_t          rstate_q [CHANNELS];
    rep_state_t          rstate_d [CHANNELS];
    logic [RW-1:0]       rcnt_q   [CHANNELS];
    logic [RW-1:0]       rcnt_d   [CHANNELS];
    logic [CHANNELS-1:0] repeat_q;
    logic [CHANNELS-1:0] repeat_d;

    // Repeat next-state: the incoming level decides, so the release cycle can never repeat
    always_comb begin
        repeat_d = '0;
        for (int ch = 0; ch < CHANNELS; ch++) begin
            rstate_d[ch] = rstate_q[ch];
            rcnt_d[ch]   = rcnt_q[ch];
            if (!level_d[ch]) begin
                rstate_d[ch] = IDLE;
                rcnt_d[ch]   = '0;
            end else if (press_d[ch]) begin
                rstate_d[ch] = ARMED;
                rcnt_d[ch]   = RW'(HOLD_CYCLES - 1);
            end else if (rstate_q[ch] == ARMED) begin
                if (rcnt_q[ch] == '0) begin
                    repeat_d[ch] = 1'b1;
                    rcnt_d[ch]   = RW'(REPEAT_CYCLES - 1);
                end else begin
                    rcnt_d[ch] = rcnt_q[ch] - RW'(1);
                end
            end
        end
    end

    // Repeat state and registered repeat pulse
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            repeat_q <= '0;
            for (int ch = 0; ch < CHANNELS; ch++) begin
                rstate_q[ch] <= IDLE;
                rcnt_q[ch]   <= '0;
            end
        end else begin
            repeat_q <= repeat_d;
            for (int ch = 0; ch < CHANNELS; ch++) begin
                rstate_q[ch] <= rstate_d[ch];
                rcnt_q[ch]   <= rcnt_d[ch];
            end
        end
    end

    assign btn_repeat = repeat_q;
`else
    // Repeat timing parameters are still part of the interface but drive nothing here
    logic [RW-1:0] unused_repeat_cfg;
    assign unused_repeat_cfg = RW'(HOLD_CYCLES) ^ RW'(REPEAT_CYCLES);

    assign btn_repeat = '0;
`endif

endmodule
